// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
//   Serial UART transmitter. One frame = start bit (0), 8 data bits LSB first,
//   one parity bit, one stop bit (1). Every bit lasts CLKS_PER_BIT clocks,
//   timed by an internal bit-rate counter. All outputs are registered.
//
// Parameters
//   CLKS_PER_BIT : clock cycles per serial bit (>= 2)
//   PARITY_ODD   : 0 = even parity, 1 = odd parity
//
// Ports
//   clk     : system clock, rising edge
//   n_rst   : asynchronous active-low reset
//   data_in : byte to send, latched when a start request is accepted
//   start   : transmit request, only acted on in IDLE
//   tx_line : serial output, idle high
//   busy    : high while a frame is in progress
//   finish  : one-cycle pulse when a frame completes
// -----------------------------------------------------------------------------
module uart_tx #(
  parameter int CLKS_PER_BIT = 2604,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [7:0] data_in,
  input  logic       start,
  output logic       tx_line,
  output logic       busy,
  output logic       finish
);

  localparam int                 CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic             r_parity;
  logic             r_tx;
  logic             r_busy;
  logic             r_finish;

  logic             w_bit_done;
  logic             w_accept;
  logic             w_tx_next;
  logic             w_busy_next;
  logic             w_finish_next;

  // Terminal count of the bit-rate counter: the current bit ends at the next edge.
  assign w_bit_done = (r_cnt == CNT_LAST);
  assign w_accept   = (r_state == S_IDLE) && start;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: the default assignment at the top keeps this block free of latches
  // on paths where no case arm assigns w_state_next.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (start)                               w_state_next = S_START;
      S_START:  if (w_bit_done)                          w_state_next = S_DATA;
      S_DATA:   if (w_bit_done && (r_bit_idx == 3'd7))   w_state_next = S_PARITY;
      S_PARITY: if (w_bit_done)                          w_state_next = S_STOP;
      S_STOP:   if (w_bit_done)                          w_state_next = S_IDLE;
      default:                                           w_state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: bit-rate counter, bit index, shift register, parity
  // ---------------------------------------------------------------------------
  // NOTE: the shift register is ordinary flop storage, so it is cleared on
  // reset like the rest; a reset mid-frame leaves no stale byte behind.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_parity  <= 1'b0;
    end else begin
      // Counter idles at 0 and restarts at each bit boundary, never passing CNT_LAST.
      if ((r_state == S_IDLE) || w_bit_done) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end

      if (w_accept) begin
        r_shift   <= data_in;
        r_parity  <= (^data_in) ^ PARITY_ODD;
        r_bit_idx <= '0;
      end else if ((r_state == S_DATA) && w_bit_done) begin
        r_shift   <= r_shift >> 1;
        r_bit_idx <= r_bit_idx + 3'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output logic: next values of the registered outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_busy_next   = (w_state_next != S_IDLE);
    w_finish_next = (r_state == S_STOP) && w_bit_done;
    case (w_state_next)
      S_START:  w_tx_next = 1'b0;
      // Crossing into the next data bit: the byte shifts at this same edge,
      // so the bit to drive is the one just above the current LSB.
      S_DATA:   w_tx_next = ((r_state == S_DATA) && w_bit_done) ? r_shift[1] : r_shift[0];
      S_PARITY: w_tx_next = r_parity;
      default:  w_tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_tx     <= 1'b1;
      r_busy   <= 1'b0;
      r_finish <= 1'b0;
    end else begin
      r_tx     <= w_tx_next;
      r_busy   <= w_busy_next;
      r_finish <= w_finish_next;
    end
  end

  assign tx_line = r_tx;
  assign busy    = r_busy;
  assign finish  = r_finish;

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx
//   Three transmitters: even and odd parity at 4 clocks/bit sharing one
//   stimulus, and the default 2604 clocks/bit with its own stimulus. A
//   time-based reference model predicts tx_line/busy/finish every cycle; the
//   directed scenarios add targeted checks on frame shape and timing.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_tx;

  localparam int N_FAST = 4;
  localparam int N_SLOW = 2604;

  logic       clk     = 1'b0;
  logic       n_rst   = 1'b0;
  logic       start_f = 1'b0;
  logic       start_s = 1'b0;
  logic [7:0] data_f  = 8'h00;
  logic [7:0] data_s  = 8'h00;
  logic [2:0] tx_o;
  logic [2:0] busy_o;
  logic [2:0] fin_o;

  int n_total = 0;
  int n_bad   = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  uart_tx #(.CLKS_PER_BIT(N_FAST), .PARITY_ODD(1'b0)) u_even (
    .clk(clk), .n_rst(n_rst), .data_in(data_f), .start(start_f),
    .tx_line(tx_o[0]), .busy(busy_o[0]), .finish(fin_o[0]));

  uart_tx #(.CLKS_PER_BIT(N_FAST), .PARITY_ODD(1'b1)) u_odd (
    .clk(clk), .n_rst(n_rst), .data_in(data_f), .start(start_f),
    .tx_line(tx_o[1]), .busy(busy_o[1]), .finish(fin_o[1]));

  uart_tx #(.CLKS_PER_BIT(N_SLOW), .PARITY_ODD(1'b0)) u_slow (
    .clk(clk), .n_rst(n_rst), .data_in(data_s), .start(start_s),
    .tx_line(tx_o[2]), .busy(busy_o[2]), .finish(fin_o[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int bit_cycles(input int i);
    return (i == 2) ? N_SLOW : N_FAST;
  endfunction

  function automatic bit odd_of(input int i);
    return (i == 1);
  endfunction

  function automatic logic req_of(input int i);
    return (i == 2) ? start_s : start_f;
  endfunction

  function automatic logic [7:0] byte_of(input int i);
    return (i == 2) ? data_s : data_f;
  endfunction

  // Whole frame as bit 0 (first on the line) .. bit 10 (stop).
  function automatic logic [10:0] frame_word(input logic [7:0] d, input bit odd);
    logic p;
    p = (($countones(d) % 2) == 1) ^ odd;
    return {1'b1, p, d, 1'b0};
  endfunction

  logic        m_active [3];
  int          m_off    [3];
  logic [10:0] m_bits   [3];
  logic        m_fin    [3];

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < 3; i++) begin
        m_active[i] <= 1'b0;
        m_off[i]    <= 0;
        m_bits[i]   <= '1;
        m_fin[i]    <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        m_fin[i] <= 1'b0;
        if (m_active[i]) begin
          if (m_off[i] == 11 * bit_cycles(i) - 1) begin
            m_active[i] <= 1'b0;
            m_fin[i]    <= 1'b1;
          end else begin
            m_off[i] <= m_off[i] + 1;
          end
        end else if (req_of(i)) begin
          m_active[i] <= 1'b1;
          m_off[i]    <= 0;
          m_bits[i]   <= frame_word(byte_of(i), odd_of(i));
        end
      end
    end
  end

  function automatic logic exp_tx(input int i);
    return m_active[i] ? m_bits[i][m_off[i] / bit_cycles(i)] : 1'b1;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        check($sformatf("cyc_tx%0d", i),   32'(tx_o[i]),   32'(exp_tx(i)));
        check($sformatf("cyc_busy%0d", i), 32'(busy_o[i]), 32'(m_active[i]));
        check($sformatf("cyc_fin%0d", i),  32'(fin_o[i]),  32'(m_fin[i]));
      end
    end
  end

  // ---------------- directed helpers (fast pair) ----------------
  logic [10:0] got_bits [2];
  int          nbusy    [2];
  int          fin_at   [2];
  int          nfin     [2];

  // Called on a negedge; returns on the first negedge after the accepting edge.
  task automatic send(input logic [7:0] d);
    data_f  = d;
    start_f = 1'b1;
    @(negedge clk);
    start_f = 1'b0;
  endtask

  // Observes 60 cycles from the first sample after acceptance. When poke_at
  // >= 0, start is raised for one cycle with data 0xFF at that sample.
  task automatic measure(input int poke_at);
    for (int j = 0; j < 2; j++) begin
      got_bits[j] = '0;
      nbusy[j]    = 0;
      fin_at[j]   = -1;
      nfin[j]     = 0;
    end
    for (int s = 0; s < 60; s++) begin
      for (int j = 0; j < 2; j++) begin
        if (busy_o[j]) nbusy[j]++;
        if (fin_o[j]) begin
          if (nfin[j] == 0) fin_at[j] = s;
          nfin[j]++;
        end
        if ((s % N_FAST == 2) && (s < 11 * N_FAST)) got_bits[j][s / N_FAST] = tx_o[j];
      end
      if (s == poke_at) begin
        start_f = 1'b1;
        data_f  = 8'hFF;
      end else if (s == poke_at + 1) begin
        start_f = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  task automatic frame_checks(input string tag, input logic [10:0] e0, input logic [10:0] e1);
    for (int j = 0; j < 2; j++) begin
      check($sformatf("%s_busy%0d", tag, j),  32'(nbusy[j]),    32'(11 * N_FAST));
      check($sformatf("%s_finat%0d", tag, j), 32'(fin_at[j]),   32'(11 * N_FAST));
      check($sformatf("%s_nfin%0d", tag, j),  32'(nfin[j]),     32'd1);
      check($sformatf("%s_bits%0d", tag, j),  32'(got_bits[j]), 32'((j == 0) ? e0 : e1));
    end
  endtask

  // ---------------- scenarios ----------------
  logic [7:0] d;
  logic       bz [100];
  logic       tz [100];
  logic       fz [100];
  int         tr [$];
  logic       prev;
  int         sb;
  int         sf;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_tx",   32'(tx_o),   32'h7);
    check("rst_busy", 32'(busy_o), 32'h0);
    check("rst_fin",  32'(fin_o),  32'h0);
    n_rst  = 1'b1;
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_tx",   32'(tx_o),   32'h7);
    check("idle_busy", 32'(busy_o), 32'h0);

    // 0x55 and 0xA7 with literal expected frames (even / odd parity).
    send(8'h55);
    measure(-1);
    frame_checks("f55", 11'b10010101010, 11'b11010101010);
    send(8'hA7);
    measure(-1);
    frame_checks("fA7", 11'b11101001110, 11'b10101001110);

    // Start plus new data during a frame: ignored, frame unchanged.
    d = 8'($urandom);
    send(d);
    measure(10);
    frame_checks("ign", frame_word(d, 1'b0), frame_word(d, 1'b1));

    // Start held high with 0x00: back-to-back frames with a 1-cycle gap.
    data_f  = 8'h00;
    start_f = 1'b1;
    @(negedge clk);
    for (int s = 0; s < 100; s++) begin
      bz[s] = busy_o[0];
      tz[s] = tx_o[0];
      fz[s] = fin_o[0];
      if (s == 50) start_f = 1'b0;
      @(negedge clk);
    end
    check("held_busy43", 32'(bz[43]), 32'd1);
    check("held_gap44",  32'(bz[44]), 32'd0);
    check("held_fin44",  32'(fz[44]), 32'd1);
    check("held_busy45", 32'(bz[45]), 32'd1);
    check("held_start2", 32'(tz[45]), 32'd0);
    check("held_par1",   32'(tz[37]), 32'd0);
    check("held_par2",   32'(tz[82]), 32'd0);
    check("held_busy88", 32'(bz[88]), 32'd1);
    check("held_end89",  32'(bz[89]), 32'd0);
    check("held_none99", 32'(bz[99]), 32'd0);

    // Random bytes, random idle gaps, random ignored requests mid-frame.
    repeat (6) begin
      d = 8'($urandom);
      repeat ($urandom_range(0, 5)) @(negedge clk);
      send(d);
      measure(int'($urandom_range(1, 40)));
      frame_checks("rnd", frame_word(d, 1'b0), frame_word(d, 1'b1));
    end

    // Asynchronous reset while sending data bit 1 of 0x3C (a 0 on the line).
    send(8'h3C);
    repeat (9) @(negedge clk);
    check("pre_rst_tx",   32'(tx_o[1:0]),   32'h0);
    check("pre_rst_busy", 32'(busy_o[1:0]), 32'h3);
    #2 n_rst = 1'b0;
    #1;
    check("async_tx",   32'(tx_o),   32'h7);
    check("async_busy", 32'(busy_o), 32'h0);
    check("async_fin",  32'(fin_o),  32'h0);
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    d = 8'($urandom);
    send(d);
    measure(-1);
    frame_checks("post_rst", frame_word(d, 1'b0), frame_word(d, 1'b1));

    // Default rate, 0x41: line runs of 1,1,5,1,2 bits between transitions.
    data_s  = 8'h41;
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    prev = 1'b1;
    sb   = 0;
    sf   = -1;
    for (int s = 0; s < 11 * N_SLOW + 50; s++) begin
      if (tx_o[2] !== prev) begin
        tr.push_back(s);
        prev = tx_o[2];
      end
      if (busy_o[2]) sb++;
      if (fin_o[2] && (sf < 0)) sf = s;
      @(negedge clk);
    end
    check("slow_ntrans", 32'(tr.size()), 32'd6);
    if (tr.size() == 6) begin
      check("slow_w0", 32'(tr[1] - tr[0]), 32'(1 * N_SLOW));
      check("slow_w1", 32'(tr[2] - tr[1]), 32'(1 * N_SLOW));
      check("slow_w2", 32'(tr[3] - tr[2]), 32'(5 * N_SLOW));
      check("slow_w3", 32'(tr[4] - tr[3]), 32'(1 * N_SLOW));
      check("slow_w4", 32'(tr[5] - tr[4]), 32'(2 * N_SLOW));
    end
    check("slow_busy",  32'(sb), 32'(11 * N_SLOW));
    check("slow_finat", 32'(sf), 32'(11 * N_SLOW));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
